// File: rtl/multibyte_add_sequencer.sv
// Adds NUM_BYTES-wide operands one byte per clock through an external 8-bit adder.
// Optional signed-overflow output enabled by defining MULTIBYTE_ADD_OVF_EN.
module multibyte_add_sequencer #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [8*NUM_BYTES-1:0]   In_A,
  input  logic [8*NUM_BYTES-1:0]   In_B,
  input  logic                     In_Cin,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [8*NUM_BYTES-1:0]   Out_Y,
  output logic                     Out_Cout,
`ifdef MULTIBYTE_ADD_OVF_EN
  output logic                     Out_Ovf,
`endif
  output logic [7:0]               Add_A,
  output logic [7:0]               Add_B,
  output logic                     Add_Cin,
  input  logic [7:0]               Add_Y,
  input  logic                     Add_Cout
);

  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned OFS_W = IDX_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [OFS_W-1:0] ofs;

  assign ofs = {idx, 3'b000};

  // Adder is driven only while a byte is in flight; quiet otherwise
  always_comb begin
    Add_A   = 8'd0;
    Add_B   = 8'd0;
    Add_Cin = 1'b0;
    if (state == RUN) begin
      Add_A   = a_reg[ofs +: 8];
      Add_B   = b_reg[ofs +: 8];
      Add_Cin = carry_reg;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      Out_Y     <= '0;
      Out_Cout  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
`ifdef MULTIBYTE_ADD_OVF_EN
      Out_Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            a_reg     <= In_A;
            b_reg     <= In_B;
            carry_reg <= In_Cin;
            idx       <= '0;
            In_Ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          Out_Y[ofs +: 8] <= Add_Y;
          carry_reg       <= Add_Cout;
          if (idx == LAST_IDX) begin
            Out_Cout  <= Add_Cout;
`ifdef MULTIBYTE_ADD_OVF_EN
            // Carry out of the MSB xor carry into it
            Out_Ovf   <= Add_Cout ^ (Add_A[7] ^ Add_B[7] ^ Add_Y[7]);
`endif
            Out_Valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          Out_Valid <= 1'b0;
          In_Ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Bench for multibyte_add_sequencer: whole-word arithmetic model plus directed vectors.
module tb_multibyte_add_sequencer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic        out_cout;
  logic [7:0]  add_a, add_b, add_y;
  logic        add_cin, add_cout;
`ifdef MULTIBYTE_ADD_OVF_EN
  logic        out_ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Environment: the combinational 8-bit adder
  assign {add_cout, add_y} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  multibyte_add_sequencer #(.NUM_BYTES(NB)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .In_A(in_a), .In_B(in_b), .In_Cin(in_cin),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Y(out_y), .Out_Cout(out_cout),
`ifdef MULTIBYTE_ADD_OVF_EN
    .Out_Ovf(out_ovf),
`endif
    .Add_A(add_a), .Add_B(add_b), .Add_Cin(add_cin),
    .Add_Y(add_y), .Add_Cout(add_cout)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                      input logic c, input int i);
    logic [63:0] mk, s, t;
    mk = (64'd1 << (8 * i)) - 64'd1;
    s  = ({32'd0, a} & mk) + ({32'd0, b} & mk) + 64'(c);
    t  = s >> (8 * i);
    return t[0];
  endfunction

  // Transaction-level model: accepted operands, byte in flight, presented result
  logic        m_ready, m_valid, m_known, m_cout, m_ovf;
  logic [31:0] m_y, cap_a, cap_b;
  logic        cap_cin;
  int          m_byte;
  logic [32:0] m_sum;

  assign m_sum = {1'b0, cap_a} + {1'b0, cap_b} + 33'(cap_cin);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_known <= 1'b1;
      m_y <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_byte <= -1;
      cap_a <= '0; cap_b <= '0; cap_cin <= 1'b0;
    end else if (m_byte >= 0) begin
      if (m_byte == NB - 1) begin
        m_byte  <= -1;
        m_valid <= 1'b1;
        m_known <= 1'b1;
        m_y     <= m_sum[31:0];
        m_cout  <= m_sum[32];
        m_ovf   <= (cap_a[31] == cap_b[31]) && (m_sum[31] != cap_a[31]);
      end else begin
        m_byte <= m_byte + 1;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0; m_ready <= 1'b1; m_known <= 1'b0;
      end
    end else if (m_ready && in_valid) begin
      cap_a <= in_a; cap_b <= in_b; cap_cin <= in_cin;
      m_ready <= 1'b0; m_byte <= 0; m_known <= 1'b0;
    end
  end

  int          cyc = 0;
  int          vt[$];
  logic [31:0] vy[$];

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] t;
    cyc++;
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_valid);
    if (m_known) begin
      check("out_y", out_y, m_y);
      check("out_cout", out_cout, m_cout);
`ifdef MULTIBYTE_ADD_OVF_EN
      if (m_valid) check("out_ovf", out_ovf, m_ovf);
`endif
    end
    if (m_byte >= 0) begin
      t = cap_a >> (8 * m_byte);
      check("add_a", add_a, t[7:0]);
      t = cap_b >> (8 * m_byte);
      check("add_b", add_b, t[7:0]);
      check("add_cin", add_cin, carry_into(cap_a, cap_b, cap_cin, m_byte));
    end else begin
      check("add_idle", {add_a, add_b, add_cin}, 17'd0);
    end
    if (out_valid) begin
      vt.push_back(cyc);
      vy.push_back(out_y);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input int stall, input logic [31:0] ey, input logic ec,
                       input logic eovf, input int ecins, input string nm);
    int n, lat, ones;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({nm, " accept"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; ones = 0;
    while (!out_valid && lat < 20) begin
      ones += int'(add_cin);
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, lat, NB);
    check({nm, " y"}, out_y, ey);
    check({nm, " cout"}, out_cout, ec);
    check({nm, " carry_bytes"}, ones, ecins);
`ifdef MULTIBYTE_ADD_OVF_EN
    check({nm, " ovf"}, out_ovf, eovf);
`else
    if (eovf === 1'bx) $display("unexpected x ovf expectation");
`endif
    repeat (stall) begin
      @(negedge clk);
      check({nm, " hold_y"}, out_y, ey);
      check({nm, " hold_valid"}, out_valid, 1);
      check({nm, " hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, " drop_valid"}, out_valid, 0);
    check({nm, " ready_back"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    logic        pc[3];

    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_y", out_y, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 32'h0000_0003, 1'b0, 1'b0, 0, "basic");
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0, 4, "ripple");
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 5, 32'h2345_6789, 1'b0, 1'b0, 0, "backpressure");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1, 3, "ovf_pos");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 3, "ovf_wrap");

    // Back-to-back with In_Valid and Out_Ready held high
    pa[0] = 32'h0000_0010; pb[0] = 32'h0000_0020; pc[0] = 1'b0;
    pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000; pc[1] = 1'b0;
    pa[2] = 32'h0000_FFFF; pb[2] = 32'h0000_0001; pc[2] = 1'b1;
    vt.delete(); vy.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = pa[i]; in_b = pb[i]; in_cin = pc[i];
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (vt.size() < 3 && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    check("b2b count", vt.size(), 3);
    if (vt.size() >= 3) begin
      check("b2b gap01", vt[1] - vt[0], 6);
      check("b2b gap12", vt[2] - vt[1], 6);
      check("b2b y0", vy[0], 32'h0000_0030);
      check("b2b y1", vy[1], 32'h0000_0000);
      check("b2b y2", vy[2], 32'h0001_0001);
    end
    out_ready = 1'b0;

    // Abort mid-operation after two bytes
    @(negedge clk);
    in_a = 32'hA5A5_A5A5; in_b = 32'h5A5A_5A5B; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort started", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort out_y", out_y, 0);
    check("abort out_cout", out_cout, 0);
    check("abort add_bus", {add_a, add_b, add_cin}, 17'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort no_result", out_valid, 0);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1, 32'h0000_0100, 1'b0, 1'b0, 1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
- Wraps the 8-bit combinational carry-skip adder to add wide operands of NUM_BYTES bytes, one byte per clock, LSB byte first.
- Sits upstream and downstream of the adder: drives its A/B/Cin, captures its Y/Cout, and chains the carry between bytes through a register.
- Operands enter through a valid/ready handshake; the full-width sum leaves through a second valid/ready handshake.

Parameters:
- NUM_BYTES, 4, operand width in bytes (legal range 2..16); data width W = 8*NUM_BYTES.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset: asynchronous, active-low.
- In_Valid  input  1  operand request valid.
- In_Ready  output  1  block can accept operands.
- In_A  input  W  operand A.
- In_B  input  W  operand B.
- In_Cin  input  1  carry-in to byte 0.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  consumer accepts result.
- Out_Y  output  W  sum.
- Out_Cout  output  1  carry-out of the top byte.
- Add_A  output  8  byte of A to the adder.
- Add_B  output  8  byte of B to the adder.
- Add_Cin  output  1  carry-in to the adder.
- Add_Y  input  8  adder sum byte.
- Add_Cout  input  1  adder carry-out.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; In_Ready = 1; Out_Valid = 0.
  - Out_Y = 0; Out_Cout = 0.
  - Internal byte index = 0; carry register = 0.
  - Add_A, Add_B and Add_Cin = 0.
- Reset asserted in any state aborts the operation immediately. No partial result is ever presented.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - In_Ready = 1.
  - On an edge with In_Valid=1: capture In_A, In_B, In_Cin; index <= 0; carry_reg <= In_Cin; go to RUN.
- RUN:
  - In_Ready = 0.
  - Combinational drive: Add_A = a_reg[8*idx+:8], Add_B = b_reg[8*idx+:8], Add_Cin = carry_reg.
  - Each edge: y_reg[8*idx+:8] <= Add_Y; carry_reg <= Add_Cout.
  - If idx == NUM_BYTES-1: Out_Cout <= Add_Cout and go to DONE. Otherwise idx <= idx+1.
  - The adder is purely combinational, so the block must not add a wait cycle between bytes.
- DONE:
  - Out_Valid = 1.
  - Out_Y and Out_Cout are held stable while Out_Valid=1 and Out_Ready=0.
  - On an edge with Out_Ready=1: go to IDLE. In_Ready rises in the next cycle.
- In IDLE and DONE, Add_A, Add_B and Add_Cin are driven 0 so the adder is quiet.
- Latency: operands accepted at edge k; Out_Valid is high from edge k+NUM_BYTES. Throughput is one operation per NUM_BYTES+2 cycles minimum.
- Arithmetic: {Out_Cout, Out_Y} = In_A + In_B + In_Cin, exact modulo 2^(W+1).
- Wrap-around: all-ones + 1 gives Out_Y = 0, Out_Cout = 1.
- Operand inputs are ignored outside IDLE, and In_Valid is ignored while In_Ready=0.
- Simultaneous events:
  - Out_Ready held high before DONE has no effect until DONE.
  - Out_Ready=1 at the first DONE cycle gives a one-cycle Out_Valid pulse.
- In_Valid may stay high across operations. A new request is taken on the first IDLE edge.

Optional Feature:
- Macro: MULTIBYTE_ADD_OVF_EN.
- When defined:
  - Adds output port Out_Ovf (1 bit): two's-complement signed overflow.
  - On the last RUN byte, Out_Ovf <= Add_Cout ^ (Add_A[7] ^ Add_B[7] ^ Add_Y[7]), i.e. carry-out xor carry-into the MSB.
  - Reset value 0. Held with Out_Y.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: Rst_n low mid-RUN (NUM_BYTES=4, after 2 bytes) -> next cycle Out_Valid=0, In_Ready=1, Out_Y=0, Out_Cout=0, Add_* = 0.
- Basic: A=0x00000001, B=0x00000002, Cin=0 -> Out_Y=0x00000003, Out_Cout=0, Out_Valid exactly 4 cycles after accept.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Out_Y=0x00000000, Out_Cout=1. Add_Cin=1 on every byte cycle.
- Backpressure: A=0x12345678, B=0x11111111, Out_Ready=0 for 5 cycles -> Out_Y=0x23456789 held stable, In_Ready=0 until 1 cycle after Out_Ready=1.
- Back-to-back: In_Valid held high with 3 operand pairs, Out_Ready=1 -> 3 results in order, each Out_Valid a 1-cycle pulse, 6 cycles apart.
- With MULTIBYTE_ADD_OVF_EN: A=0x7FFFFFFF, B=0x00000001 -> Out_Y=0x80000000, Out_Cout=0, Out_Ovf=1.
- With MULTIBYTE_ADD_OVF_EN: A=0xFFFFFFFF, B=0x00000001 -> Out_Y=0, Out_Cout=1, Out_Ovf=0.
